// File: rtl/reset_sequencer.sv
// Staged fabric reset sequencer: synchronises init/lock, filters lock, releases resets in order.
// Optional saturating lock-loss counter enabled by RESET_SEQ_LOCK_LOSS_CNT_EN.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES    = 4,
    parameter int unsigned LOCK_FILTER   = 1024,
    parameter int unsigned STAGE_DELAY   = 256,
    parameter int unsigned SW_RST_CYCLES = 64
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  INIT_DONE,
    input  logic                  PLL_LOCK,
    input  logic                  SW_RST_REQ,
    output logic [NUM_STAGES-1:0] RESETN_OUT,
    output logic                  SEQ_DONE,
    output logic [2:0]            STATE,
    output logic [7:0]            LOCK_LOSS_CNT
);

    localparam int unsigned FW  = $clog2(LOCK_FILTER);
    localparam int unsigned DW  = $clog2(STAGE_DELAY + 1);
    localparam int unsigned HW  = $clog2(SW_RST_CYCLES + 1);
    localparam int unsigned SGW = $clog2(NUM_STAGES + 1);

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SW_HOLD   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [FW-1:0]           filt_q, filt_d;
    logic [DW-1:0]           dly_q, dly_d;
    logic [SGW-1:0]          stg_q, stg_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [NUM_STAGES-1:0]   rst_q, rst_d;
    logic                    done_q, done_d;
    logic                    init_s1, init_s, lock_s1, lock_s;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            init_s1 <= 1'b0;
            init_s  <= 1'b0;
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            init_s1 <= INIT_DONE;
            init_s  <= init_s1;
            lock_s1 <= PLL_LOCK;
            lock_s  <= lock_s1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= WAIT_INIT;
            filt_q  <= '0;
            dly_q   <= '0;
            stg_q   <= '0;
            hold_q  <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            dly_q   <= dly_d;
            stg_q   <= stg_d;
            hold_q  <= hold_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    // Every counter and output defaults to its cleared value, so any exit asserts all stages at once.
    always_comb begin
        state_d = state_q;
        filt_d  = '0;
        dly_d   = '0;
        stg_d   = '0;
        hold_d  = '0;
        rst_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            WAIT_INIT: begin
                if (init_s) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    if (filt_q == FW'(LOCK_FILTER - 1)) begin
                        state_d = RELEASE;
                        rst_d   = NUM_STAGES'(1);
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else begin
                    rst_d = rst_q;
                    stg_d = stg_q;
                    dly_d = dly_q + 1'b1;
                    if (dly_q == DW'(STAGE_DELAY - 1)) begin
                        dly_d = '0;
                        if (stg_q == SGW'(NUM_STAGES - 1)) begin
                            state_d = RUN;
                            rst_d   = '1;
                            done_d  = 1'b1;
                        end else begin
                            stg_d = stg_q + 1'b1;
                            rst_d = (rst_q << 1) | NUM_STAGES'(1);
                        end
                    end
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (SW_RST_REQ) begin
                    state_d = SW_HOLD;
                end else begin
                    rst_d  = '1;
                    done_d = 1'b1;
                end
            end
            SW_HOLD: begin
                if (!lock_s || (hold_q == HW'(SW_RST_CYCLES - 1))) begin
                    state_d = WAIT_LOCK;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = WAIT_INIT;
        endcase
    end

    assign RESETN_OUT = rst_q;
    assign SEQ_DONE   = done_q;
    assign STATE      = state_q;

`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt;
    logic       loss_evt;

    assign loss_evt = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            loss_cnt <= '0;
        end else if (loss_evt && (loss_cnt != '1)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign LOCK_LOSS_CNT = loss_cnt;
`else
    assign LOCK_LOSS_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random lock/sw-request traffic
// checked every cycle against a timeline-based reference model.
module tb_reset_sequencer;

    localparam int NS  = 3;
    localparam int LF  = 8;
    localparam int SD  = 4;
    localparam int SWC = 5;

    logic          CLK = 1'b0;
    logic          RESETN;
    logic          INIT_DONE;
    logic          PLL_LOCK;
    logic          SW_RST_REQ;
    logic [NS-1:0] RESETN_OUT;
    logic          SEQ_DONE;
    logic [2:0]    STATE;
    logic [7:0]    LOCK_LOSS_CNT;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    reset_sequencer #(
        .NUM_STAGES   (NS),
        .LOCK_FILTER  (LF),
        .STAGE_DELAY  (SD),
        .SW_RST_CYCLES(SWC)
    ) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .INIT_DONE    (INIT_DONE),
        .PLL_LOCK     (PLL_LOCK),
        .SW_RST_REQ   (SW_RST_REQ),
        .RESETN_OUT   (RESETN_OUT),
        .SEQ_DONE     (SEQ_DONE),
        .STATE        (STATE),
        .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: phase (0..4), length of the current synced-high lock run,
    // edges elapsed since stage 0 was released, cycles spent in software hold.
    int m_state, m_run, m_trel, m_hold, m_llc;
    bit m_l1, m_ls, m_i1, m_is;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_trel = 0; m_hold = 0; m_llc = 0;
        m_l1 = 0; m_ls = 0; m_i1 = 0; m_is = 0;
    endtask

    task automatic model_lose(input bit counted);
        m_state = 1;
        m_run   = 0;
`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
        if (counted && m_llc < 255) m_llc++;
`else
        if (counted) m_llc = 0;
`endif
    endtask

    task automatic model_edge();
        bit ls, is;
        ls = m_ls;
        is = m_is;
        case (m_state)
            0: if (is) begin m_state = 1; m_run = 0; end
            1: begin
                if (!ls) m_run = 0;
                else if (m_run + 1 == LF) begin m_state = 2; m_trel = 0; m_run = 0; end
                else m_run++;
            end
            2: begin
                if (!ls) model_lose(1'b1);
                else begin
                    m_trel++;
                    if (m_trel == NS * SD) m_state = 3;
                end
            end
            3: begin
                if (!ls) model_lose(1'b1);
                else if (SW_RST_REQ) begin m_state = 4; m_hold = 0; end
            end
            default: begin
                if (!ls) model_lose(1'b0);
                else begin
                    m_hold++;
                    if (m_hold == SWC) begin m_state = 1; m_run = 0; end
                end
            end
        endcase
        m_ls = m_l1; m_l1 = PLL_LOCK;
        m_is = m_i1; m_i1 = INIT_DONE;
    endtask

    function automatic logic [NS-1:0] exp_out();
        logic [NS-1:0] v;
        v = '0;
        for (int k = 0; k < NS; k++) begin
            if (m_state == 3) v[k] = 1'b1;
            else if (m_state == 2) v[k] = (m_trel >= k * SD);
        end
        return v;
    endfunction

    task automatic compare_all();
        chk("resetn_out", 32'(RESETN_OUT), 32'(exp_out()));
        chk("seq_done", 32'(SEQ_DONE), 32'(m_state == 3));
        chk("state", 32'(STATE), 32'(m_state));
        chk("lock_loss_cnt", 32'(LOCK_LOSS_CNT), 32'(m_llc));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
        cyc++;
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(STATE) != s && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(STATE), 32'(s));
    endtask

    // PLL_LOCK has just been raised; the first step is edge E0.
    task automatic measure_release(input string tag);
        int t_b[NS];
        int t_done;
        for (int k = 0; k < NS; k++) t_b[k] = -1;
        t_done = -1;
        for (int e = 0; e < 30; e++) begin
            step();
            for (int k = 0; k < NS; k++)
                if (t_b[k] < 0 && RESETN_OUT[k]) t_b[k] = e;
            if (t_done < 0 && SEQ_DONE) t_done = e;
        end
        for (int k = 0; k < NS; k++)
            chk($sformatf("%s_rise%0d", tag, k), 32'(t_b[k]), 32'(LF + 1 + k * SD));
        chk({tag, "_done"}, 32'(t_done), 32'(LF + 1 + NS * SD));
        chk({tag, "_state"}, 32'(STATE), 32'd3);
    endtask

    task automatic async_reset_pulse();
        #1;
        RESETN = 1'b0;
        #1;
        model_reset();
        chk("async_out", 32'(RESETN_OUT), 32'd0);
        chk("async_state", 32'(STATE), 32'd0);
        chk("async_done", 32'(SEQ_DONE), 32'd0);
        chk("async_llc", 32'(LOCK_LOSS_CNT), 32'd0);
        #1;
        RESETN = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RESETN = 1'b0; INIT_DONE = 1'b0; PLL_LOCK = 1'b0; SW_RST_REQ = 1'b0;
        model_reset();
        #12;
        chk("rst_out", 32'(RESETN_OUT), 32'd0);
        chk("rst_done", 32'(SEQ_DONE), 32'd0);
        chk("rst_state", 32'(STATE), 32'd0);
        chk("rst_llc", 32'(LOCK_LOSS_CNT), 32'd0);
        #1;
        RESETN = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Nominal release
        INIT_DONE = 1'b1;
        wait_state(1, 10, "reach_wait_lock");
        for (int i = 0; i < 3; i++) step();
        PLL_LOCK = 1'b1;
        measure_release("nominal");

        // Lock loss in RUN, then relock
        PLL_LOCK = 1'b0;
        step();
        step();
        chk("loss_hold_e1", 32'(RESETN_OUT), 32'd7);
        step();
        chk("loss_out_e2", 32'(RESETN_OUT), 32'd0);
        chk("loss_done_e2", 32'(SEQ_DONE), 32'd0);
        chk("loss_state_e2", 32'(STATE), 32'd1);
`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
        chk("loss_llc", 32'(LOCK_LOSS_CNT), 32'd1);
`else
        chk("loss_llc", 32'(LOCK_LOSS_CNT), 32'd0);
`endif
        PLL_LOCK = 1'b1;
        measure_release("relock");

        // Software reset pulse
        SW_RST_REQ = 1'b1;
        step();
        SW_RST_REQ = 1'b0;
        chk("sw_state_e0", 32'(STATE), 32'd4);
        chk("sw_out_e0", 32'(RESETN_OUT), 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("sw_state_e4", 32'(STATE), 32'd4);
        step();
        chk("sw_state_e5", 32'(STATE), 32'd1);
        wait_state(3, 40, "sw_rerun");

        // Lock loss and software request on the same edge
        PLL_LOCK = 1'b0;
        step();
        step();
        SW_RST_REQ = 1'b1;
        step();
        SW_RST_REQ = 1'b0;
        chk("simul_state", 32'(STATE), 32'd1);
        for (int i = 0; i < 3; i++) step();

        // Glitchy lock: 5 high, 1 low, then high
        PLL_LOCK = 1'b1;
        for (int i = 0; i < 5; i++) step();
        PLL_LOCK = 1'b0;
        step();
        PLL_LOCK = 1'b1;
        measure_release("glitch");

        // Async reset mid-release with two stages out
        PLL_LOCK = 1'b0;
        wait_state(1, 10, "pre_async_wl");
        PLL_LOCK = 1'b1;
        n = 0;
        while (RESETN_OUT != 3'b011 && n < 40) begin
            step();
            n++;
        end
        chk("pre_async_out", 32'(RESETN_OUT), 32'd3);
        async_reset_pulse();
        wait_state(3, 60, "async_rerun");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (PLL_LOCK) PLL_LOCK = ($urandom_range(0, 59) != 0);
            else          PLL_LOCK = ($urandom_range(0, 2) == 0);
            SW_RST_REQ = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 199) == 0) INIT_DONE = ~INIT_DONE;
            step();
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
        end
        SW_RST_REQ = 1'b0;
        INIT_DONE  = 1'b1;

        // Lock-loss count saturation
        PLL_LOCK = 1'b0;
        for (int i = 0; i < 4; i++) step();
        wait_state(1, 10, "sat_start");
        for (int ev = 0; ev < 300; ev++) begin
            PLL_LOCK = 1'b1;
            wait_state(2, 20, "sat_release");
            PLL_LOCK = 1'b0;
            for (int i = 0; i < 3; i++) step();
        end
`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
        chk("llc_sat", 32'(LOCK_LOSS_CNT), 32'd255);
`else
        chk("llc_sat", 32'(LOCK_LOSS_CNT), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
